mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store initiator that sits between the MIPS datapath's memory stage and the word-wide `RAM` block. It accepts one byte, halfword or word access at a time over a valid/ready request port. It drives the RAM's `write_enable`/`address`/`in` port and reads `out`. Sub-word loads are extracted and extended here; sub-word stores are done as read-modify-write. Completion is reported with a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of request and RAM address.

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: rising-edge clock shared with `RAM`.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal (treated as misaligned).
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_error` out 1: misaligned or illegal access, valid with `resp_valid`.
- `ram_write_enable` out 1: to RAM `write_enable`.
- `ram_address` out ADDR_W: to RAM `address`; always word-aligned, `{req_addr[ADDR_W-1:2], 2'b00}`.
- `ram_in` out 32: to RAM `in`.
- `ram_out` in 32: from RAM `out`; valid the cycle after `ram_address` is presented.

## Operation
- Byte lanes are little-endian. `addr[1:0]=0` selects bits 7:0, and so on up to 3 selecting bits 31:24. A halfword at offset 0 is bits 15:0; at offset 2 it is bits 31:16.
- Alignment rules:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=0`.
  - Any violation, or size 11, goes straight to RESP with `resp_error=1` and makes no RAM access.
- On acceptance, the request is latched: address, size, signed, write, wdata.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RESP.
  - Load: IDLE → RD_ADDR → RD_DATA → RESP → IDLE.
  - Word store: IDLE → WR → RESP → IDLE.
  - Byte/half store: IDLE → RD_ADDR → RD_DATA → WR → RESP → IDLE.
  - Error: IDLE → RESP → IDLE.
- What happens in each state:
  - RD_ADDR: drives `ram_address`, `ram_write_enable=0`.
  - RD_DATA: holds the address. For a load, latches the extracted/extended result. For a store, latches a merged word with only the addressed lanes replaced by `req_wdata` low bits.
  - WR: drives `ram_write_enable=1`, `ram_address`, `ram_in` = merged word (or the full wdata for a word store), for exactly one cycle.
  - RESP: `resp_valid=1`.
- `req_valid` while not IDLE is ignored; the requester must hold it until accepted.

## Timing
- Acceptance edge = E0. `resp_valid` is high in the cycle after:
  - E1 for an error.
  - E2 for a word store.
  - E3 for a load.
  - E4 for a sub-word store.
- Throughput: the next request can be accepted on the edge that ends RESP + 1 (IDLE is at least one cycle).
- Reset values:
  - State IDLE.
  - `ram_write_enable=0`, `ram_address=0`, `ram_in=0`.
  - `resp_valid=0`, `resp_rdata=0`, `resp_error=0`.
  - `req_ready=1` (decoded from IDLE).
- Reset mid-operation aborts the access immediately (asynchronous). `ram_write_enable` falls without waiting for an edge. No response is produced, and RAM is left as it was before the aborted write cycle.
- `ram_write_enable` is never high outside WR.
- All RAM-facing outputs are registered.

## Structure
- Shared package `mem_pkg`:
  - `mem_size_t` enum (BYTE, HALF, WORD).
  - `mau_state_t` enum of the five states.
  - Constant `WORD_BYTES=4`.
- One combinational sub-module, `byte_lane_unit`: given offset, size, signed, the RAM word and wdata, it produces the extracted load value and the merged store word. The FSM and registers live in `mem_access_unit`.

## Test plan
- Word store 0x1194D7FF to 0x0, then word load 0x0 → RAM word 0 = 0x1194D7FF; `resp_rdata=0x1194D7FF` 3 cycles after acceptance; store `resp_valid` 2 cycles after acceptance.
- Word store 0x178AB8FF to 0x4, then byte store 0xAB to 0x5 → RAM word 4 = 0x178AABFF; `ram_write_enable` high exactly one cycle per store.
- Loads on word 4 = 0x178AABFF:
  - signed byte at 0x4 → 0xFFFFFFFF
  - unsigned byte at 0x4 → 0x000000FF
  - signed half at 0x4 → 0xFFFFABFF
  - signed half at 0x6 → 0x0000178A
- Misaligned word load at 0x2, half store at 0x5, and size 11 → `resp_error=1` one cycle after acceptance, `resp_rdata=0`, no `ram_write_enable`, memory unchanged.
- `reset` pulsed while in RD_DATA of a byte store to 0x4 → `ram_write_enable` stays 0, no `resp_valid`, word 4 unchanged, `req_ready=1` after reset.
- `req_valid` held high across a load → second request accepted only after return to IDLE; two responses, each one cycle wide, in order.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store initiator in front of the word-wide RAM.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWr,
        StResp
    } mau_state_t;

    // Raw size code 2'b11 is illegal and reported like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = offset[0];
            2'b10:   is_misaligned = |offset;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane steering: extracts/extends sub-word loads and merges sub-word stores.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  mem_size_t   i_size,
    input  logic        i_signed,
    input  logic [31:0] i_ram_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_val,
    output logic [31:0] o_merged
);

    logic [31:0]           w_shifted;
    logic [WORD_BYTES-1:0] w_lane_en;
    logic [31:0]           w_wdata_rep;

    always_comb begin
        w_shifted   = i_ram_word >> {i_offset, 3'b000};
        o_load_val  = i_ram_word;
        w_lane_en   = '1;
        w_wdata_rep = i_wdata;
        o_merged    = i_ram_word;
        case (i_size)
            SzByte: begin
                o_load_val  = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
                w_lane_en   = 4'b0001 << i_offset;
                w_wdata_rep = {4{i_wdata[7:0]}};
            end
            SzHalf: begin
                o_load_val  = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
                w_lane_en   = 4'b0011 << {i_offset[1], 1'b0};
                w_wdata_rep = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
        // Replicated store data lets each enabled lane take its byte in place.
        for (int i = 0; i < WORD_BYTES; i++) begin
            o_merged[8*i +: 8] = w_lane_en[i] ? w_wdata_rep[8*i +: 8] : i_ram_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator: one access at a time, sub-word stores as read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_error,
    output logic              o_ram_write_enable,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic [31:0]       o_ram_in,
    input  logic [31:0]       i_ram_out
);

    mau_state_t        r_state, w_state_d;
    logic              r_write, w_write_d;
    mem_size_t         r_size, w_size_d;
    logic              r_signed, w_signed_d;
    logic [1:0]        r_offset, w_offset_d;
    logic [31:0]       r_wdata, w_wdata_d;
    logic [31:0]       r_data, w_data_d;
    logic              r_error, w_error_d;
    logic              r_ram_we, w_ram_we_d;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_d;
    logic [31:0]       r_ram_in, w_ram_in_d;
    logic              r_resp_valid, w_resp_valid_d;
    logic [31:0]       r_resp_rdata, w_resp_rdata_d;
    logic              r_resp_error, w_resp_error_d;

    logic [31:0]       w_load_val;
    logic [31:0]       w_merged;

    byte_lane_unit u_lanes (
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_signed   (r_signed),
        .i_ram_word (i_ram_out),
        .i_wdata    (r_wdata),
        .o_load_val (w_load_val),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_state_d      = r_state;
        w_write_d      = r_write;
        w_size_d       = r_size;
        w_signed_d     = r_signed;
        w_offset_d     = r_offset;
        w_wdata_d      = r_wdata;
        w_data_d       = r_data;
        w_error_d      = r_error;
        w_ram_we_d     = 1'b0;
        w_ram_addr_d   = r_ram_addr;
        w_ram_in_d     = r_ram_in;
        w_resp_valid_d = 1'b0;
        w_resp_rdata_d = '0;
        w_resp_error_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_write_d  = i_req_write;
                    w_signed_d = i_req_signed;
                    w_offset_d = i_req_addr[1:0];
                    w_wdata_d  = i_req_wdata;
                    w_data_d   = '0;
                    if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                        w_error_d = 1'b1;
                        w_state_d = StResp;
                    end else begin
                        w_error_d    = 1'b0;
                        w_size_d     = mem_size_t'(i_req_size);
                        w_ram_addr_d = {i_req_addr[ADDR_W-1:2], 2'b00};
                        if (i_req_write && (i_req_size == 2'b10)) begin
                            w_state_d  = StWr;
                            w_ram_we_d = 1'b1;
                            w_ram_in_d = i_req_wdata;
                        end else begin
                            w_state_d = StRdAddr;
                        end
                    end
                end
            end
            StRdAddr: w_state_d = StRdData;
            StRdData: begin
                if (r_write) begin
                    w_state_d  = StWr;
                    w_ram_we_d = 1'b1;
                    w_ram_in_d = w_merged;
                end else begin
                    w_state_d = StResp;
                    w_data_d  = w_load_val;
                end
            end
            StWr: w_state_d = StResp;
            StResp: begin
                w_state_d      = StIdle;
                w_resp_valid_d = 1'b1;
                w_resp_error_d = r_error;
                w_resp_rdata_d = (r_write || r_error) ? '0 : r_data;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_write      <= 1'b0;
            r_size       <= SzByte;
            r_signed     <= 1'b0;
            r_offset     <= '0;
            r_wdata      <= '0;
            r_data       <= '0;
            r_error      <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_in     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_write      <= w_write_d;
            r_size       <= w_size_d;
            r_signed     <= w_signed_d;
            r_offset     <= w_offset_d;
            r_wdata      <= w_wdata_d;
            r_data       <= w_data_d;
            r_error      <= w_error_d;
            r_ram_we     <= w_ram_we_d;
            r_ram_addr   <= w_ram_addr_d;
            r_ram_in     <= w_ram_in_d;
            r_resp_valid <= w_resp_valid_d;
            r_resp_rdata <= w_resp_rdata_d;
            r_resp_error <= w_resp_error_d;
        end
    end

    assign o_req_ready        = (r_state == StIdle);
    assign o_resp_valid       = r_resp_valid;
    assign o_resp_rdata       = r_resp_rdata;
    assign o_resp_error       = r_resp_error;
    assign o_ram_write_enable = r_ram_we;
    assign o_ram_address      = r_ram_addr;
    assign o_ram_in           = r_ram_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write, req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_error;
    logic [31:0]       resp_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_in, ram_out;

    logic [31:0] ram [16];
    logic [7:0]  ref_mem [64];
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_write        (req_write),
        .i_req_size         (req_size),
        .i_req_signed       (req_signed),
        .i_req_addr         (req_addr),
        .i_req_wdata        (req_wdata),
        .o_resp_valid       (resp_valid),
        .o_resp_rdata       (resp_rdata),
        .o_resp_error       (resp_error),
        .o_ram_write_enable (ram_we),
        .o_ram_address      (ram_addr),
        .o_ram_in           (ram_in),
        .i_ram_out          (ram_out)
    );

    always #5 clk = ~clk;

    // Word-wide synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr[5:2]] <= ram_in;
        ram_out <= ram[ram_addr[5:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_load(input int a, input int sz, input bit sg);
        int          n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a+i];
        if (sg && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[4*idx+i];
        return v;
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
        int          n, exp_lat, lat, we_cnt, widx;
        logic        exp_err, got_err;
        logic [31:0] exp_rd;
        n       = 1 << sz;
        exp_err = (sz == 2'd3) || (a % n != 0);
        exp_lat = exp_err ? 1 : (w ? ((sz == 2'd2) ? 2 : 4) : 3);
        exp_rd  = (exp_err || w) ? 32'h0 : ref_load(a, sz, sg);
        widx    = int'(a[5:2]);
        @(negedge clk);
        check("req_ready idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        we_cnt    = 0;
        obs       = '0;
        got_err   = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            if (ram_we) we_cnt++;
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat     = k;
                obs     = resp_rdata;
                got_err = resp_error;
            end
        end
        check("resp latency", lat, exp_lat);
        check("resp_rdata", obs, exp_rd);
        check("resp_error", {31'h0, got_err}, {31'h0, exp_err});
        check("ram_we cycles", we_cnt, (!exp_err && w) ? 1 : 0);
        if (!exp_err) check("ram_address", ram_addr, {a[31:2], 2'b00});
        @(posedge clk);
        #1;
        check("resp pulse width", {31'h0, resp_valid}, 32'h0);
        if (!exp_err && w) for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
        check("ram word", ram[widx], ref_word(widx));
    endtask

    initial begin
        logic [31:0] obs, exp_a, exp_b, d1, d2, ra;
        int          seen, n_resp, k1, k2, sw_k;
        logic        switched;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        #12;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset ram_we", {31'h0, ram_we}, 32'h0);
        check("reset ram_address", ram_addr, 32'h0);
        check("reset ram_in", ram_in, 32'h0);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset resp_error", {31'h0, resp_error}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 32'(4*i), $urandom, obs);

        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1194D7FF, obs);
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, obs);
        check("word load 0x0", obs, 32'h1194D7FF);
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h178AB8FF, obs);
        do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AB, obs);
        check("word 4 after byte store", ram[1], 32'h178AABFF);
        do_req(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, obs);
        check("signed byte 0x4", obs, 32'hFFFFFFFF);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, obs);
        check("unsigned byte 0x4", obs, 32'h000000FF);
        do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, obs);
        check("signed half 0x4", obs, 32'hFFFFABFF);
        do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, obs);
        check("signed half 0x6", obs, 32'h0000178A);

        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, obs);
        do_req(1'b1, 2'd1, 1'b0, 32'h5, 32'h00001234, obs);
        do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, obs);
        check("word 4 after errors", ram[1], 32'h178AABFF);

        // Reset lands in RD_DATA of a byte store to 0x4.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort ram_we", {31'h0, ram_we}, 32'h0);
        check("abort req_ready", {31'h0, req_ready}, 32'h1);
        check("abort ram_address", ram_addr, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid || ram_we) seen++;
        end
        check("abort no activity", seen, 0);
        check("abort word 4 unchanged", ram[1], 32'h178AABFF);
        check("abort ready after", {31'h0, req_ready}, 32'h1);

        // req_valid held across a load: the next request waits for IDLE.
        exp_a = ref_load(4, 2, 1'b0);
        exp_b = ref_load(8, 0, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        switched = 1'b0; sw_k = -1; n_resp = 0; k1 = -1; k2 = -1; d1 = '0; d2 = '0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid) begin
                n_resp++;
                if (n_resp == 1) begin k1 = k; d1 = resp_rdata; end
                else begin k2 = k; d2 = resp_rdata; end
            end
            if (req_ready && !switched) begin
                switched = 1'b1;
                sw_k     = k;
                req_addr = 32'h8; req_size = 2'd0; req_signed = 1'b1;
            end else if (switched && k == sw_k + 1) begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("held: first idle cycle", sw_k, 3);
        check("held: response count", n_resp, 2);
        check("held: first resp cycle", k1, 3);
        check("held: second resp cycle", k2, 7);
        check("held: first rdata", d1, exp_a);
        check("held: second rdata", d2, exp_b);

        for (int i = 0; i < 60; i++) begin
            ra = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ra = ra & 32'h3C;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, $urandom, obs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
